// File: rtl/envia_senal_pkg.sv
// Shared definitions for the envia_senal serial transmitter.
package envia_senal_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned DEF_BIT_CLKS   = 434;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/tx_fifo.sv
// Byte queue ahead of the shifter; flags come from the registered occupancy.
module tx_fifo
    import envia_senal_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_BITS,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the occupancy counter defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/envia_senal.sv
// 8N1 serial transmitter with a small input FIFO and sticky overflow flag.
module envia_senal
    import envia_senal_pkg::*;
#(
    parameter int unsigned BIT_CLKS   = DEF_BIT_CLKS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy,
    output logic       TxD_full,
    output logic       TxD_overflow
);

    localparam int unsigned TW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [TW-1:0] TMAX = TW'(BIT_CLKS - 1);

    tx_state_t            state, state_nx;
    logic [TW-1:0]        timer, timer_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 txd_q, txd_nx;
    logic                 ovf_q;
    logic                 bit_end;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_dout;

    tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (TxD_start),
        .pop   (fifo_pop),
        .din   (TxD_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end      = (timer == TMAX);
    assign TxD          = txd_q;
    assign TxD_busy     = (state != IDLE) || !fifo_empty;
    assign TxD_full     = fifo_full;
    assign TxD_overflow = ovf_q;

    // Next-state logic; the line level is computed from the current state and
    // registered, so TxD trails the state by one cycle uniformly for every bit.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        fifo_pop   = 1'b0;
        txd_nx     = 1'b1;
        if (state != IDLE) timer_nx = bit_end ? '0 : timer + 1'b1;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_nx = fifo_dout;
                    state_nx = START;
                end
            end
            START: begin
                txd_nx = 1'b0;
                if (bit_end) begin
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                txd_nx = shreg[bit_idx];
                if (bit_end) begin
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state_nx = STOP;
                end
            end
            STOP: begin
                txd_nx = 1'b1;
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_nx = fifo_dout;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, bit timer, shift data and registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
            txd_q   <= txd_nx;
        end
    end

    // Sticky overflow: any write attempted while the queue is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ovf_q <= 1'b0;
        else if (TxD_start && fifo_full) ovf_q <= 1'b1;
    end

endmodule

// File: tb/tb_envia_senal.sv
// Self-checking bench for envia_senal: fast instance (BIT_CLKS=4) plus a
// full-rate instance looped back into a behavioural receiver.
module tb_envia_senal;

    localparam int HMAX = 4096;
    localparam int SLOW = 434;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        int         busy_cycles;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_f = 1'b0;
    logic [7:0] data_f = 8'h00;
    logic       txd_f, busy_f, full_f, ovf_f;
    logic       start_s = 1'b0;
    logic [7:0] data_s = 8'h00;
    logic       txd_s, busy_s, full_s, ovf_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_bad = 0;
    logic       hist_txd  [HMAX];
    logic       hist_busy [HMAX];
    logic [7:0] rx_q [$];
    vec_t       tbl [6];

    envia_senal #(.BIT_CLKS(4), .FIFO_DEPTH(4)) u_fast (
        .clk(clk), .rst_n(rst_n), .TxD_start(start_f), .TxD_data(data_f),
        .TxD(txd_f), .TxD_busy(busy_f), .TxD_full(full_f), .TxD_overflow(ovf_f)
    );

    envia_senal #(.BIT_CLKS(SLOW), .FIFO_DEPTH(4)) u_slow (
        .clk(clk), .rst_n(rst_n), .TxD_start(start_s), .TxD_data(data_s),
        .TxD(txd_s), .TxD_busy(busy_s), .TxD_full(full_s), .TxD_overflow(ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // hist[k] holds the fast instance's outputs during the cycle after edge k.
    always @(negedge clk) begin
        if (cyc < HMAX) begin
            hist_txd[cyc]  = txd_f;
            hist_busy[cyc] = busy_f;
        end
    end

    // Behavioural 8N1 receiver on the full-rate line, sampling mid-bit.
    initial begin
        logic       prev;
        logic       ok;
        logic [7:0] b;
        prev = 1'b1;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txd_s) begin
                repeat (SLOW / 2) @(negedge clk);
                ok = (txd_s == 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (SLOW) @(negedge clk);
                    b[k] = txd_s;
                end
                repeat (SLOW) @(negedge clk);
                ok = ok && (txd_s == 1'b1);
                if (ok) rx_q.push_back(b);
                else    rx_bad++;
            end
            prev = txd_s;
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [39:0] expand(input logic [9:0] fr);
        logic [39:0] r;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 4; j++)
                r[4*i+j] = fr[i];
        return r;
    endfunction

    task automatic check_frame(input string name, input int base, input logic [9:0] fr);
        logic [39:0] act;
        logic [39:0] exp;
        exp = expand(fr);
        for (int k = 0; k < 40; k++) act[k] = hist_txd[base+k];
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: line got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_f && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (busy_f) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy got 1 expected 0 within 1000 cycles");
        end
        @(negedge clk);
    endtask

    task automatic write_fast(input logic [7:0] d, output int n);
        @(negedge clk);
        start_f = 1'b1;
        data_f  = d;
        @(negedge clk);
        start_f = 1'b0;
        n = cyc;
    endtask

    initial begin
        int n;
        int bc;
        logic [7:0] lb [4];
        logic [9:0] ovf_frames [5];
        logic all_hi;

        tbl[0] = '{8'h55, 10'b1010101010, 41};
        tbl[1] = '{8'h00, 10'b1000000000, 41};
        tbl[2] = '{8'hFF, 10'b1111111110, 41};
        tbl[3] = '{8'h81, 10'b1100000010, 41};
        tbl[4] = '{8'h7E, 10'b1011111100, 41};
        tbl[5] = '{8'h3C, 10'b1001111000, 41};
        ovf_frames = '{10'b1000000010, 10'b1000000100, 10'b1000000110,
                       10'b1000001000, 10'b1000001010};
        lb = '{8'h00, 8'h7E, 8'h81, 8'hFF};

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_txd", int'(txd_f), 1);
        check_val("rst_busy", int'(busy_f), 0);
        check_val("rst_full", int'(full_f), 0);
        check_val("rst_ovf", int'(ovf_f), 0);
        check_val("rst_txd_slow", int'(txd_s), 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frames from the table
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            write_fast(tbl[i].data, n);
            repeat (46) @(negedge clk);
            check_val($sformatf("latency_hi_%0d", i), int'(hist_txd[n+1]), 1);
            check_frame($sformatf("frame_%0d", i), n + 2, tbl[i].frame);
            bc = 0;
            for (int k = 0; k < 46; k++) bc += int'(hist_busy[n+k]);
            check_val($sformatf("busy_cycles_%0d", i), bc, tbl[i].busy_cycles);
            check_val($sformatf("busy_drop_%0d", i), int'(hist_busy[n+41]), 0);
        end

        // Back-to-back 0x00, 0xFF: contiguous frames
        wait_idle();
        @(negedge clk);
        start_f = 1'b1;
        data_f  = 8'h00;
        @(negedge clk);
        data_f  = 8'hFF;
        n = cyc;
        @(negedge clk);
        start_f = 1'b0;
        repeat (86) @(negedge clk);
        check_frame("b2b_first", n + 2, 10'b1000000000);
        check_frame("b2b_second", n + 42, 10'b1111111110);
        check_val("b2b_busy_last", int'(hist_busy[n+80]), 1);
        check_val("b2b_busy_drop", int'(hist_busy[n+81]), 0);

        // Six writes into a depth-4 queue: sixth is dropped
        wait_idle();
        @(negedge clk);
        start_f = 1'b1;
        data_f  = 8'h01;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) n = cyc;
            if (i == 4) begin
                check_val("ovf_full_after5", int'(full_f), 1);
                check_val("ovf_clear_after5", int'(ovf_f), 0);
            end
            if (i < 5) data_f = 8'(i + 2);
            else       start_f = 1'b0;
        end
        check_val("ovf_set_after6", int'(ovf_f), 1);
        check_val("ovf_full_after6", int'(full_f), 1);
        repeat (215) @(negedge clk);
        for (int k = 0; k < 5; k++)
            check_frame($sformatf("ovf_frame_%0d", k), n + 2 + 40*k, ovf_frames[k]);
        all_hi = 1'b1;
        for (int k = 202; k < 212; k++) all_hi = all_hi & hist_txd[n+k];
        check_val("ovf_no_sixth", int'(all_hi), 1);
        check_val("ovf_busy_drop", int'(hist_busy[n+201]), 0);
        check_val("ovf_sticky", int'(ovf_f), 1);

        // Reset during DATA bit 3 of 0xA3, then a clean 0x3C frame
        wait_idle();
        write_fast(8'hA3, n);
        repeat (19) @(negedge clk);
        check_val("pre_rst_bit3", int'(txd_f), 0);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_txd", int'(txd_f), 1);
        check_val("midrst_busy", int'(busy_f), 0);
        check_val("midrst_full", int'(full_f), 0);
        check_val("midrst_ovf", int'(ovf_f), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        start_f = 1'b1;
        data_f  = 8'h3C;
        @(negedge clk);
        start_f = 1'b0;
        n = cyc;
        repeat (46) @(negedge clk);
        check_val("postrst_idle_hi", int'(hist_txd[n+1]), 1);
        check_frame("postrst_frame", n + 2, 10'b1001111000);
        bc = 0;
        for (int k = 0; k < 46; k++) bc += int'(hist_busy[n+k]);
        check_val("postrst_busy_cycles", bc, 41);

        // Full-rate loopback into the receiver model
        @(negedge clk);
        start_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_s = lb[i];
            @(negedge clk);
        end
        start_s = 1'b0;
        for (int t = 0; t < 20000 && rx_q.size() < 4; t++) @(negedge clk);
        check_val("loop_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size())
                check_val($sformatf("loop_byte_%0d", i), int'(rx_q[i]), int'(lb[i]));
        check_val("loop_framing_errs", rx_bad, 0);
        repeat (300) @(negedge clk);
        check_val("loop_busy_end", int'(busy_s), 0);
        check_val("loop_line_idle", int'(txd_s), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/envia_senal.md
ENVIA_SENAL -- requirements
Module: envia_senal

Interface
REQ-001 Parameter BIT_CLKS, default 434, clk cycles per serial bit (50 MHz / 115200 baud, rounded).
REQ-002 Parameter FIFO_DEPTH, default 4, number of bytes queued ahead of the shifter; power of two.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 TxD_start  input  1  write strobe; one byte is offered per cycle it is high.
REQ-006 TxD_data  input  8  byte offered with TxD_start.
REQ-007 TxD  output  1  serial line, 8N1, idle high.
REQ-008 TxD_busy  output  1  high while a frame is shifting or the FIFO is non-empty.
REQ-009 TxD_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 TxD_overflow  output  1  sticky: a write arrived while TxD_full was high.

Function
REQ-011 Write acceptance: TxD_start=1 and TxD_full=0 at a rising edge pushes TxD_data into the FIFO.
REQ-012 Write with TxD_full=1 is dropped and sets TxD_overflow, even if a pop occurs in the same cycle.
REQ-013 Full/empty flags are derived from registered occupancy; no combinational path from TxD_start to TxD_full.
REQ-014 Shifter FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: TxD=1; if FIFO non-empty, pop head into shift register and enter START.
REQ-016 START: TxD=0 for exactly BIT_CLKS cycles, then DATA.
REQ-017 DATA: 8 bits, LSB first, each held exactly BIT_CLKS cycles; 3-bit bit index, then STOP.
REQ-018 STOP: TxD=1 for exactly BIT_CLKS cycles; on last cycle, if FIFO non-empty, pop and enter START directly, else IDLE.
REQ-019 Back-to-back frames are contiguous: frame period exactly 10*BIT_CLKS cycles, no extra idle cycle.
REQ-020 Latency: write accepted at edge N into empty idle block -> pop at edge N+1 -> TxD low after edge N+2.
REQ-021 Bit timer counts 0..BIT_CLKS-1 and wraps; width ceil(log2(BIT_CLKS)).
REQ-022 TxD is driven from a register (glitch-free).
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-024 Simultaneous push and pop with FIFO non-full and non-empty: both occur, occupancy unchanged.
REQ-025 TxD_busy drops to 0 in the cycle after the last STOP cycle when FIFO is empty.

Reset
REQ-026 rst_n low forces immediately: TxD=1, TxD_busy=0, TxD_full=0, TxD_overflow=0, FSM=IDLE, timer=0, FIFO empty.
REQ-027 Reset mid-frame aborts the frame; the truncated frame is not resumed and queued bytes are discarded.
REQ-028 Reset deassertion is used synchronously by the design only through clk-edge updates; first write accepted on the first edge with rst_n=1.

Structure
REQ-029 Shared package holds: state enum (IDLE, START, DATA, STOP), FRAME_BITS=10, DATA_BITS=8, default BIT_CLKS and FIFO_DEPTH.
REQ-030 FIFO is a separate sub-module tx_fifo (push, pop, data in/out, full, empty, same clk/rst_n); shifter FSM lives in envia_senal.
REQ-031 The block pairs with the existing serial receiver at the same BIT_CLKS; loopback TxD->RxD reproduces each byte.

Verification
REQ-032 BIT_CLKS=4, write 0x55 once -> TxD: 0 (4 clk), 1,0,1,0,1,0,1,0 (4 clk each), 1 (4 clk); TxD_busy high exactly 41 cycles.
REQ-033 BIT_CLKS=4, write 0x00,0xFF on consecutive cycles -> two contiguous frames, 80 cycles total, no high gap between first stop and second start.
REQ-034 FIFO_DEPTH=4, 6 consecutive writes 0x01..0x06 while first frame shifts -> 0x01..0x05 transmitted, 0x06 dropped, TxD_overflow=1 after the 6th write.
REQ-035 Write 0xA3, assert rst_n=0 during DATA bit 3 -> TxD=1 immediately, TxD_busy=0; after release, write 0x3C -> clean 0x3C frame.
REQ-036 Loopback to existing receiver at BIT_CLKS=434, send 0x00,0x7E,0x81,0xFF -> receiver reports same four bytes with data-ready pulses.
